// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Parametrised register file with NUM_RD combinational read ports, one write
// port, optional write-to-read bypass, optional hardwired-zero entry 0, a
// pending-write scoreboard for hazard detection and a sequential clear sweep
// that zeroes every entry after reset.
//
// Ports
//   RF_clk       clock, all state changes on the rising edge
//   RF_rst       synchronous active-high reset (restarts the clear sweep)
//   RF_EN        write enable
//   RF_WA/RF_WD  write address / data
//   RF_ADDR      packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   RF_RS        packed read data,     port i = [i*DATA_W +: DATA_W]
//   RF_RSV_EN    reserve request for RF_RSV_ADDR (marks entry pending)
//   RF_RSV_ADDR  address to reserve
//   RF_PEND      per read port: addressed entry has an outstanding reservation
//   RF_READY     clear sweep finished, writes and reservations accepted
// ---------------------------------------------------------------------------
module reg_file_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                       RF_clk,
   input  logic                       RF_rst,
   input  logic                       RF_EN,
   input  logic [ADDR_W-1:0]          RF_WA,
   input  logic [DATA_W-1:0]          RF_WD,
   input  logic [NUM_RD*ADDR_W-1:0]   RF_ADDR,
   output logic [NUM_RD*DATA_W-1:0]   RF_RS,
   input  logic                       RF_RSV_EN,
   input  logic [ADDR_W-1:0]          RF_RSV_ADDR,
   output logic [NUM_RD-1:0]          RF_PEND,
   output logic                       RF_READY
);

   localparam int unsigned      DEPTH    = 32'd1 << ADDR_W;
   // Sweep index of the final entry; reaching it ends the clear sweep.
   localparam logic [ADDR_W:0]  CLR_LAST = (ADDR_W + 1)'(DEPTH - 32'd1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   state_e              state_q;
   logic [ADDR_W:0]     clr_cnt_q;
   logic                ready_q;
   logic [DEPTH-1:0]    pend_q;
   logic [DEPTH-1:0]    pend_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                ready_s;
   logic                wr_ok_s;
   logic                rsv_ok_s;
   logic                sweep_we_s;
   logic                wr_we_s;

   // True when the address selects the hardwired-zero entry.
   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG != 32'd0) && (addr == '0);
   endfunction

   assign ready_s    = (state_q == ST_READY);
   assign wr_ok_s    = ready_s && RF_EN && !is_zero_reg(RF_WA);
   assign rsv_ok_s   = ready_s && RF_RSV_EN && !is_zero_reg(RF_RSV_ADDR);
   // Storage is never touched on a reset edge; the sweep zeroes it afterwards.
   assign sweep_we_s = !RF_rst && (state_q == ST_CLEAR);
   assign wr_we_s    = !RF_rst && wr_ok_s;
   assign RF_READY   = ready_q;

   // Scoreboard next state: a reservation wins over a same-cycle write
   // because it names a newer producer for that entry.
   always_comb begin
      pend_d = pend_q;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         pend_d[k] = (rsv_ok_s && (RF_RSV_ADDR == ADDR_W'(k))) ? 1'b1 :
                     (wr_ok_s  && (RF_WA       == ADDR_W'(k))) ? 1'b0 :
                     pend_q[k];
      end
   end

   // Control FSM: clear sweep, ready flag and pending bits.
   always_ff @(posedge RF_clk) begin
      if (RF_rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
         pend_q    <= '0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + (ADDR_W + 1)'(1);
               if (clr_cnt_q == CLR_LAST) begin
                  state_q <= ST_READY;
                  ready_q <= 1'b1;
               end
            end
            ST_READY: begin
               pend_q <= pend_d;
            end
            default: begin
               state_q   <= ST_CLEAR;
               clr_cnt_q <= '0;
               ready_q   <= 1'b0;
               pend_q    <= '0;
            end
         endcase
      end
   end

   // Storage array: sweep zeroing during CLEAR, normal writes in READY.
   always_ff @(posedge RF_clk) begin
      if (sweep_we_s) begin
         mem_q[clr_cnt_q[ADDR_W-1:0]] <= '0;
      end else if (wr_we_s) begin
         mem_q[RF_WA] <= RF_WD;
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] addr_s;
      logic              zero_s;
      logic              hit_s;
      logic [DATA_W-1:0] rs_s;
      logic              pend_s;

      assign addr_s = RF_ADDR[g*ADDR_W +: ADDR_W];
      assign zero_s = is_zero_reg(addr_s);
      // Same-cycle write forwarding to this port.
      assign hit_s  = (BYPASS != 32'd0) && RF_EN && ready_s && (RF_WA == addr_s);

      // Read mux: zero while clearing or for entry 0, then bypass, then array.
      always_comb begin
         rs_s = '0;
         if (!ready_s || zero_s) begin
            rs_s = '0;
         end else if (hit_s) begin
            rs_s = RF_WD;
         end else begin
            rs_s = mem_q[addr_s];
         end
      end

      // A bypassed write satisfies the reservation this very cycle.
      always_comb begin
         pend_s = 1'b0;
         if (!ready_s || zero_s) begin
            pend_s = 1'b0;
         end else begin
            pend_s = pend_q[addr_s] && !hit_s;
         end
      end

      assign RF_RS[g*DATA_W +: DATA_W] = rs_s;
      assign RF_PEND[g]                = pend_s;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
// Drives one bypassing and one non-bypassing register file with the same
// stimulus and compares both against a behavioural model of the file.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [AW-1:0]     wa;
   logic [DW-1:0]     wd;
   logic [NR*AW-1:0]  addr;
   logic              rsv_en;
   logic [AW-1:0]     rsv_addr;

   logic [NR*DW-1:0]  rs_b, rs_n;
   logic [NR-1:0]     pend_b, pend_n;
   logic              rdy_b, rdy_n;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // behavioural model of the file contents
   logic [DW-1:0] m_mem  [DEPTH];
   bit            m_pend [DEPTH];
   bit            m_ready = 1'b0;
   int            m_clr   = 0;

   always #5 clk = ~clk;

   reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
      .RF_clk(clk), .RF_rst(rst), .RF_EN(en), .RF_WA(wa), .RF_WD(wd),
      .RF_ADDR(addr), .RF_RS(rs_b), .RF_RSV_EN(rsv_en), .RF_RSV_ADDR(rsv_addr),
      .RF_PEND(pend_b), .RF_READY(rdy_b));

   reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
      .RF_clk(clk), .RF_rst(rst), .RF_EN(en), .RF_WA(wa), .RF_WD(wd),
      .RF_ADDR(addr), .RF_RS(rs_n), .RF_RSV_EN(rsv_en), .RF_RSV_ADDR(rsv_addr),
      .RF_PEND(pend_n), .RF_READY(rdy_n));

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_rs(input int p, input bit byp);
      logic [AW-1:0] a;
      a = addr[p*AW +: AW];
      if (!m_ready || a == 5'd0) return '0;
      if (byp && en && wa == a)  return wd;
      return m_mem[a];
   endfunction

   function automatic logic exp_pend(input int p, input bit byp);
      logic [AW-1:0] a;
      a = addr[p*AW +: AW];
      if (!m_ready || a == 5'd0) return 1'b0;
      if (byp && en && wa == a)  return 1'b0;
      return m_pend[a];
   endfunction

   // Effect of one rising edge on the model.
   task automatic model_update();
      if (rst) begin
         m_ready = 1'b0;
         m_clr   = 0;
         foreach (m_pend[k]) m_pend[k] = 1'b0;
      end else if (!m_ready) begin
         m_clr++;
         if (m_clr == DEPTH) begin
            m_ready = 1'b1;
            foreach (m_mem[k]) m_mem[k] = '0;
         end
      end else begin
         if (en && wa != 5'd0) begin
            m_mem[wa]  = wd;
            m_pend[wa] = 1'b0;
         end
         if (rsv_en && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // Count edges until READY rises; must be exactly DEPTH.
   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (rdy_b !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check(name, 64'(n), 64'd32);
      check({name, "_nb"}, 64'(rdy_n), 64'd1);
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("ready_byp",   64'(rdy_b), 64'(m_ready));
         check("ready_nobyp", 64'(rdy_n), 64'(m_ready));
         for (int p = 0; p < NR; p++) begin
            check($sformatf("rs%0d_byp", p),     64'(rs_b[p*DW +: DW]), 64'(exp_rs(p, 1'b1)));
            check($sformatf("rs%0d_nobyp", p),   64'(rs_n[p*DW +: DW]), 64'(exp_rs(p, 1'b0)));
            check($sformatf("pend%0d_byp", p),   64'(pend_b[p]),        64'(exp_pend(p, 1'b1)));
            check($sformatf("pend%0d_nobyp", p), 64'(pend_n[p]),        64'(exp_pend(p, 1'b0)));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset for 3 edges while write/reserve requests are active
      rst = 1'b1; en = 1'b1; wa = 5'd5; wd = 32'h1111_1111;
      rsv_en = 1'b1; rsv_addr = 5'd7; addr = '0;
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      wait_ready("clear_latency");
      en = 1'b0; rsv_en = 1'b0;

      // every entry reads zero, nothing pending after the sweep
      for (int i = 0; i < DEPTH / 2; i++) begin
         addr = {5'(2 * i + 1), 5'(2 * i)};
         #1;
         check("swept_zero", 64'(rs_b), 64'd0);
         check("swept_pend", 64'(pend_b), 64'd0);
         tick();
      end

      // write x5 with both ports reading it
      en = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; addr = {5'd5, 5'd5};
      #1;
      check("byp_p0", 64'(rs_b[31:0]), 64'hDEAD_BEEF);
      check("byp_p1", 64'(rs_b[63:32]), 64'hDEAD_BEEF);
      check("nobyp_old", 64'(rs_n[31:0]), 64'd0);
      tick();
      en = 1'b0;
      #1;
      check("nobyp_new", 64'(rs_n[63:32]), 64'hDEAD_BEEF);

      // hardwired zero: write and reserve of x0 have no effect
      en = 1'b1; wa = 5'd0; wd = 32'h1234_5678; addr = {5'd0, 5'd0};
      #1;
      check("x0_byp", 64'(rs_b), 64'd0);
      tick();
      en = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd0;
      tick();
      rsv_en = 1'b0;
      #1;
      check("x0_read", 64'(rs_n), 64'd0);
      check("x0_pend", 64'(pend_b), 64'd0);

      // reserve x7, then write it
      rsv_en = 1'b1; rsv_addr = 5'd7;
      tick();
      rsv_en = 1'b0; addr = {5'd7, 5'd7};
      #1;
      check("x7_pend", 64'(pend_b), 64'd3);
      en = 1'b1; wa = 5'd7; wd = 32'h55;
      #1;
      check("x7_pend_byp", 64'(pend_b), 64'd0);
      check("x7_pend_nobyp", 64'(pend_n), 64'd3);
      tick();
      en = 1'b0;
      #1;
      check("x7_pend_after", 64'(pend_n), 64'd0);
      check("x7_data", 64'(rs_n[31:0]), 64'h55);

      // reserve and write x9 in one cycle: reservation survives
      en = 1'b1; wa = 5'd9; wd = 32'hAA; rsv_en = 1'b1; rsv_addr = 5'd9; addr = {5'd9, 5'd9};
      tick();
      en = 1'b0; rsv_en = 1'b0;
      #1;
      check("x9_data", 64'(rs_b[31:0]), 64'hAA);
      check("x9_pend", 64'(pend_b), 64'd3);

      // write x3, reset, then reset again mid-sweep at clr_cnt == 10
      en = 1'b1; wa = 5'd3; wd = 32'h1;
      tick();
      en = 1'b0; addr = {5'd3, 5'd3};
      #1;
      check("x3_data", 64'(rs_b[31:0]), 64'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready("restart_latency");
      addr = {5'd9, 5'd3};
      #1;
      check("x3_cleared", 64'(rs_b), 64'd0);
      check("pend_cleared", 64'(pend_b), 64'd0);
      tick();

      // randomized traffic with small address pool to force collisions
      for (int c = 0; c < 800; c++) begin
         rst      = ($urandom_range(0, 299) == 0);
         en       = 1'($urandom_range(0, 1));
         wa       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         wd       = $urandom;
         rsv_en   = ($urandom_range(0, 2) == 0);
         rsv_addr = 5'($urandom_range(0, 7));
         addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         if ($urandom_range(0, 7) == 0) addr = {5'($urandom), 5'($urandom)};
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the MCU core; successor to the fixed 32x32, two-read-port register file. Adds configurable data width, depth and read-port count, optional write-to-read bypass, a hardwired-zero entry, a pending-write scoreboard for pipeline hazard detection, and a sequential clear sweep on reset. Sits between decode (read addresses, reservations) and writeback (write port).

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2: number of read ports (1..4)
- ZERO_REG, 1: 1 = entry 0 reads 0, is never written and is never pending
- BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports

- RF_clk  in  1  clock; all state changes on the rising edge
- RF_rst  in  1  reset, synchronous, active-high
- RF_EN  in  1  write enable
- RF_WA  in  ADDR_W  write address
- RF_WD  in  DATA_W  write data
- RF_ADDR  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- RF_RS  out  NUM_RD*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
- RF_RSV_EN  in  1  reserve request: mark RF_RSV_ADDR as pending a write
- RF_RSV_ADDR  in  ADDR_W  address to reserve
- RF_PEND  out  NUM_RD  per read port: addressed entry has an outstanding reservation
- RF_READY  out  1  clear sweep finished; file accepts writes and reservations

## Operation
- States: CLEAR, READY. Sweep counter clr_cnt, ADDR_W+1 bits.
- RF_rst high at an edge: state <= CLEAR, clr_cnt <= 0, all pending bits <= 0. Reset mid-sweep or in READY restarts the sweep from 0.
- CLEAR, RF_rst low: each edge writes 0 to entry clr_cnt, clr_cnt += 1; at the edge where clr_cnt == DEPTH-1 is written, state <= READY.
- CLEAR: RF_EN and RF_RSV_EN ignored; RF_RS = 0 on all ports; RF_PEND = 0; RF_READY = 0.
- READY: write when RF_EN=1 and not (ZERO_REG and RF_WA==0): entry[RF_WA] <= RF_WD.
- Read (combinational), port i with address a: ZERO_REG and a==0 -> 0; else BYPASS and RF_EN and READY and RF_WA==a -> RF_WD; else entry[a].
- Scoreboard, READY only: write to address w clears pend[w]; RF_RSV_EN sets pend[RF_RSV_ADDR]. Reserve and write to same address in one cycle -> pend stays 1 (reserve wins; newer producer). Reserve of entry 0 with ZERO_REG=1 ignored.
- RF_PEND[i] = pend[a] and not (BYPASS and RF_EN and RF_WA==a); forced 0 for a==0 when ZERO_REG=1.
- Multiple read ports with the same address return identical data and pending flags.
- BYPASS=0: reads return pre-edge contents; written value visible on the cycle after the edge.

## Timing
- Reset values: RF_READY=0, RF_PEND=0, RF_RS=0, all pend bits 0; entries become 0 progressively.
- Clear latency: RF_READY rises exactly DEPTH cycles after the first edge with RF_rst low (32 for defaults); RF_rst held high keeps clr_cnt at 0.
- Read data and RF_PEND: zero-cycle combinational from RF_ADDR, RF_WA, RF_WD, RF_EN.
- Write and reservation effects: visible after the next rising edge (earlier for reads only via bypass).
- No handshake stalls: writes/reservations presented while RF_READY=0 are dropped, not queued; the caller gates on RF_READY.

## Test plan
- Reset held 3 cycles, then released -> RF_READY low for exactly 32 cycles, then high; all 32 entries read 0; write/reserve attempts during sweep have no effect.
- READY: write 0xDEADBEEF to x5, read x5 on ports 0 and 1 same cycle -> both 0xDEADBEEF (BYPASS=1); with BYPASS=0, old value 0 that cycle, 0xDEADBEEF next cycle.
- Write 0x12345678 to x0 -> x0 reads 0 on every port; RF_RSV_EN to x0 -> RF_PEND stays 0.
- Reserve x7 -> RF_PEND=1 on a port reading x7 next cycle; write x7 with 0x55 -> RF_PEND=0 same cycle (bypass), bit cleared after edge.
- Same cycle reserve x9 and write x9 with 0xAA -> after edge x9=0xAA, RF_PEND for x9 = 1.
- Write x3=0x1 in READY, assert RF_rst mid-sweep at clr_cnt=10 -> sweep restarts, RF_READY rises 32 cycles after release, x3 reads 0, pend bits 0.
